// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and defaults for the programmable sequence generator.
// Includes state encoding and the legacy 12-step reset pattern.
package seq_gen_pkg;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    typedef enum logic {
        IDLE = S_IDLE,
        RUN  = S_RUN
    } state_t;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_WIDTH = 1;

    // Step i lives at bit i; low 12 bits are the legacy fixed pattern.
    localparam logic [15:0] DEF_INIT = {4'h0, 12'hD94};

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control, table-write and step-output bundle of the sequence generator.
// The master drives control and writes; the slave produces steps.
interface seq_pattern_gen_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 1
);
    localparam int AW = $clog2(DEPTH);

    logic             start;
    logic             stop;
    logic             en;
    logic             mode_loop;
    logic [AW:0]      len;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             sof;
    logic             done;
    logic             busy;

    modport master (
        output start, stop, en, mode_loop, len,
        output wr_en, wr_addr, wr_data,
        input  out, out_valid, sof, done, busy
    );

    modport slave (
        input  start, stop, en, mode_loop, len,
        input  wr_en, wr_addr, wr_data,
        output out, out_valid, sof, done, busy
    );

endinterface

// File: rtl/seq_pattern_mem.sv
// DEPTH x WIDTH pattern table: reset to INIT, one sync write port,
// one combinational read port.
module seq_pattern_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 1,
    parameter int AW    = $clog2(DEPTH),
    parameter logic [DEPTH*WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT[i*WIDTH +: WIDTH];
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/seq_pattern_gen.sv
// Programmable sequence generator: plays a writable table for len
// steps, one-shot or looping, with pause, stop and frame marker.
import seq_gen_pkg::*;

module seq_pattern_gen #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = $clog2(DEPTH),
    parameter logic [DEPTH*WIDTH-1:0] INIT = (DEPTH*WIDTH)'(DEF_INIT)
) (
    input logic clk,
    input logic rst,
    seq_pattern_gen_if.slave bus
);

    state_t           state;
    state_t           state_n;
    logic [AW-1:0]    idx;
    logic [AW:0]      len_q;
    logic             loop_q;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic             sof_q;
    logic             done_q;
    logic             accept;
    logic             last;
    logic             len_ok;

    assign len_ok = (bus.len != '0) && (bus.len <= (AW+1)'(DEPTH));
    assign last   = ((AW+1)'(idx) == len_q - (AW+1)'(1));

    seq_pattern_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW),
        .INIT  (INIT)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en && (state == IDLE)),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.stop && len_ok) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_n = IDLE;
                end else if (bus.en && last && !loop_q) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            done_q      <= 1'b0;
            if (accept) begin
                idx    <= '0;
                len_q  <= bus.len;
                loop_q <= bus.mode_loop;
            end else if (state == RUN) begin
                // stop outranks both the step and the last-step exit
                if (bus.stop) begin
                    out_q <= '0;
                    idx   <= '0;
                end else if (bus.en) begin
                    out_q       <= rd_data;
                    out_valid_q <= 1'b1;
                    sof_q       <= (idx == '0);
                    if (last) begin
                        idx    <= '0;
                        done_q <= !loop_q;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sof       = sof_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state == RUN);

endmodule
